// File: rtl/regfile_pkg.sv
// regfile_pkg: shared regfile geometry and write-scheduler state encoding
package regfile_pkg;
  localparam int RF_ADDR_W = 5;
  localparam int RF_DATA_W = 32;
  localparam int RF_LAST_ADDR = 31;
  typedef enum logic {SCHED_IDLE = 1'b0, SCHED_CLEAR = 1'b1} sched_state_e;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: 2-way round-robin arbiter; pointer moves to the loser after a contended grant
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt,
  output logic       ptr
);
  always_comb begin
    gnt[0] = en && req[0] && (!req[1] || !ptr);
    gnt[1] = en && req[1] && (!req[0] || ptr);
  end
  always_ff @(posedge clk)
    if (rst) ptr <= 1'b0;
    else if (en && &req) ptr <= !ptr;
endmodule

// File: rtl/regfile_wport_sched.sv
// regfile_wport_sched: shares the regfile write port between two requesters and a sequenced clear
// Optional REGFILE_WSCHED_CNT_EN adds saturating per-requester handshake counters.
module regfile_wport_sched
  import regfile_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W,
  parameter int DATA_W = RF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  input  logic              clr_req,
  output logic              busy,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              grant_id
`ifdef REGFILE_WSCHED_CNT_EN
  ,
  output logic [15:0]       gnt_cnt0,
  output logic [15:0]       gnt_cnt1
`endif
);
  sched_state_e state, state_nxt;
  logic [ADDR_W-1:0] clr_cnt, sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic [1:0] gnt;
  logic en, ptr, clr_last;
  assign en = (state == SCHED_IDLE) && !clr_req;
  assign busy = (state == SCHED_CLEAR);
  // rf_waddr carries the clear address while busy, so it doubles as the end-of-clear marker
  assign clr_last = busy && (rf_waddr == ADDR_W'(RF_LAST_ADDR));
  assign sel_addr = gnt[1] ? req1_addr : req0_addr;
  assign sel_data = gnt[1] ? req1_data : req0_data;
  rr_arb2 u_arb (
    .clk(clk),
    .rst(rst),
    .req({req1_valid, req0_valid}),
    .en (en),
    .gnt(gnt),
    .ptr(ptr)
  );
  always_comb begin
    req0_ready = en && (!req1_valid || !ptr);
    req1_ready = en && (!req0_valid || ptr);
    state_nxt = (state == SCHED_IDLE && clr_req) ? SCHED_CLEAR : clr_last ? SCHED_IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= SCHED_IDLE;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      grant_id <= 1'b0;
      clr_cnt  <= ADDR_W'(1);
    end else begin
      state <= state_nxt;
      if (clr_last) begin
        rf_we   <= 1'b0;
        clr_cnt <= ADDR_W'(1);
      end else if (busy || clr_req) begin
        rf_we    <= 1'b1;
        rf_waddr <= clr_cnt;
        rf_wdata <= '0;
        clr_cnt  <= clr_cnt + ADDR_W'(1);
      end else if (|gnt) begin
        rf_we    <= |sel_addr;
        grant_id <= gnt[1];
        if (|sel_addr) begin
          rf_waddr <= sel_addr;
          rf_wdata <= sel_data;
        end
      end else rf_we <= 1'b0;
    end
  end
`ifdef REGFILE_WSCHED_CNT_EN
  always_ff @(posedge clk) begin
    if (rst || clr_req) begin
      gnt_cnt0 <= '0;
      gnt_cnt1 <= '0;
    end else begin
      if (req0_valid && req0_ready && gnt_cnt0 != 16'hFFFF) gnt_cnt0 <= gnt_cnt0 + 16'd1;
      if (req1_valid && req1_ready && gnt_cnt1 != 16'hFFFF) gnt_cnt1 <= gnt_cnt1 + 16'd1;
    end
  end
`endif
endmodule
